// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the 16KB video SRAM between the ULA video
// fetcher (absolute same-cycle priority) and latched CPU accesses.
//
// Ports:
//   clk28, rst_n          28MHz clock, synchronous active-low reset
//   video_busy, video_va  ULA owns the SRAM this cycle / its address
//   video_data            SRAM read data towards the ULA
//   cpu_req/we/a/din      CPU request (rising edge starts a transaction)
//   cpu_dout, cpu_ack     read data register, one-cycle completion pulse
//   cpu_wait_n            low while a CPU transaction is pending
//   sram_a/d_o/d_oe/we_n  SRAM pins (driven), sram_d_i SRAM read data
//   err                   sticky watchdog timeout flag
//
// Optional: define VRAM_TIMEOUT_EN to enable the pending-request
// watchdog (TIMEOUT cycles); otherwise err is tied low.
module vram_arbiter #(
   parameter int ACC_CYCLES = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        video_busy,
   input  logic [13:0] video_va,
   output logic [7:0]  video_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [13:0] cpu_a,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ack,
   output logic        cpu_wait_n,
   output logic [13:0] sram_a,
   output logic [7:0]  sram_d_o,
   output logic        sram_d_oe,
   output logic        sram_we_n,
   input  logic [7:0]  sram_d_i,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_DONE
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'(ACC_CYCLES - 1);

   state_t      state;
   state_t      state_n;
   logic [2:0]  cnt;
   logic [2:0]  cnt_n;
   logic        req_q;
   logic [13:0] a_r;
   logic [7:0]  d_r;
   logic        we_r;
   logic [7:0]  dout_n;
   logic        accept;
   logic        cpu_go;
   logic        pending;
   logic        tmo_hit;

   assign accept  = cpu_req && !req_q && (state == ST_IDLE);
   assign pending = (state == ST_WAIT) || (state == ST_ACCESS);

   // CPU owns the pins only in ACCESS and only when video is idle,
   // so video always wins within the same cycle.
   assign cpu_go     = (state == ST_ACCESS) && !video_busy;
   assign sram_a     = cpu_go ? a_r : video_va;
   assign sram_d_o   = d_r;
   assign sram_d_oe  = cpu_go && we_r;
   // Strobe released on the last access cycle to give data hold.
   assign sram_we_n  = !(cpu_go && we_r && (cnt < CNT_LAST));
   assign video_data = sram_d_i;
   assign cpu_ack    = (state == ST_DONE);

`ifdef VRAM_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

   logic [TW-1:0] tmo_cnt;
   logic          err_r;

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (accept) begin
         tmo_cnt <= '0;
      end else if (pending) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   // Fires on the TIMEOUT-th pending cycle.
   assign tmo_hit = pending && (tmo_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (tmo_hit) begin
         err_r <= 1'b1;
      end
   end

   assign err = err_r;
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dout_n  = cpu_dout;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_n = video_busy ? ST_WAIT : ST_ACCESS;
               cnt_n   = '0;
            end
         end
         ST_WAIT: begin
            if (tmo_hit) begin
               state_n = ST_DONE;
               if (!we_r) dout_n = 8'hFF;
            end else if (!video_busy) begin
               state_n = ST_ACCESS;
               cnt_n   = '0;
            end
         end
         ST_ACCESS: begin
            if (tmo_hit) begin
               state_n = ST_DONE;
               if (!we_r) dout_n = 8'hFF;
            end else if (video_busy) begin
               // Aborted by video: the whole access restarts.
               state_n = ST_WAIT;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_DONE;
               if (!we_r) dout_n = sram_d_i;
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         req_q      <= 1'b0;
         cpu_dout   <= 8'hFF;
         cpu_wait_n <= 1'b1;
         a_r        <= '0;
         d_r        <= '0;
         we_r       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         req_q      <= cpu_req;
         cpu_dout   <= dout_n;
         cpu_wait_n <= !((state_n == ST_WAIT) ||
                         (state_n == ST_ACCESS));
         if (accept) begin
            a_r  <= cpu_a;
            d_r  <= cpu_din;
            we_r <= cpu_we;
         end
      end
   end

endmodule
